mem_port_arbiter: RTL

Round-robin arbiter that shares one generic memory port (address / wdata / req / gnt / rvalid / rdata / we / be) between `NUM_PORTS` requesters. Upstream, each requester sees the same req/gnt/rvalid protocol it would see from the memory directly. The block tracks the requester ID of every granted transaction in an in-order ID FIFO, so each `mem_rvalid_i` is steered back to the requester that issued it. It sits between core-side memory clients (e.g. fetch, load/store, PTW) and a single memory or cache port.

---
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid memory port between NUM_PORTS requesters.
// An in-order ID FIFO steers each downstream rvalid back to the requester that issued it.
module mem_port_arbiter #(
   parameter int unsigned NUM_PORTS       = 2,
   parameter int unsigned ADDRESS_SIZE    = 64,
   parameter int unsigned DATA_WIDTH      = 64,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic [NUM_PORTS-1:0]                   req_i,
   input  logic [NUM_PORTS*ADDRESS_SIZE-1:0]      address_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]        data_wdata_i,
   input  logic [NUM_PORTS-1:0]                   data_we_i,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]      data_be_i,
   output logic [NUM_PORTS-1:0]                   gnt_o,
   output logic [NUM_PORTS-1:0]                   rvalid_o,
   output logic [DATA_WIDTH-1:0]                  rdata_o,
   output logic [ADDRESS_SIZE-1:0]                mem_address_o,
   output logic [DATA_WIDTH-1:0]                  mem_wdata_o,
   output logic                                   mem_req_o,
   output logic                                   mem_we_o,
   output logic [DATA_WIDTH/8-1:0]                mem_be_o,
   input  logic                                   mem_gnt_i,
   input  logic                                   mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]                  mem_rdata_i,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
   output logic                                   err_o
);

   localparam int unsigned IDW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned SUM_W = IDW + 1;
   localparam int unsigned BEW   = DATA_WIDTH / 8;
   localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [IDW-1:0]   PORT_LAST = IDW'(NUM_PORTS - 1);
   localparam logic [SUM_W-1:0] PORT_NUM  = SUM_W'(NUM_PORTS);

   typedef enum logic {
      ARB  = 1'b0,
      HOLD = 1'b1
   } arb_state_e;

   arb_state_e       lock_q, lock_d;
   logic [IDW-1:0]   sel_q, sel_d;
   logic [IDW-1:0]   rr_q, rr_d;
   logic [IDW-1:0]   fifo_q [MAX_OUTSTANDING];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic [IDW-1:0]   sel;
   logic             sel_valid;
   logic             push;
   logic             pop;
   logic             found;
   logic [SUM_W-1:0] cand;

   logic [ADDRESS_SIZE-1:0] addr_a  [NUM_PORTS];
   logic [DATA_WIDTH-1:0]   wdata_a [NUM_PORTS];
   logic [BEW-1:0]          be_a    [NUM_PORTS];

   for (genvar k = 0; k < NUM_PORTS; k++) begin : g_unpack
      assign addr_a[k]  = address_i[k*ADDRESS_SIZE +: ADDRESS_SIZE];
      assign wdata_a[k] = data_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      assign be_a[k]    = data_be_i[k*BEW +: BEW];
   end

   // Selection, downstream mux, upstream steering and next state
   always_comb begin
      sel           = sel_q;
      sel_valid     = 1'b0;
      found         = 1'b0;
      cand          = '0;
      lock_d        = lock_q;
      sel_d         = sel_q;
      rr_d          = rr_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      cnt_d         = cnt_q;
      err_d         = err_q;
      gnt_o         = '0;
      rvalid_o      = '0;
      mem_req_o     = 1'b0;
      mem_address_o = '0;
      mem_wdata_o   = '0;
      mem_we_o      = 1'b0;
      mem_be_o      = '0;

      if (lock_q == HOLD) begin
         sel_valid = 1'b1;
      end else if (cnt_q != CNT_FULL) begin
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand = {1'b0, rr_q} + SUM_W'(i);
            if (cand >= PORT_NUM) cand = cand - PORT_NUM;
            if (!found && req_i[cand[IDW-1:0]]) begin
               found = 1'b1;
               sel   = cand[IDW-1:0];
            end
         end
         sel_valid = found;
      end
      // Reset must silence the port combinationally, even with requests pending
      sel_valid = sel_valid & ~rst_i;

      push = sel_valid & mem_gnt_i;
      pop  = mem_rvalid_i & (cnt_q != '0) & ~rst_i;

      if (sel_valid) begin
         mem_req_o     = 1'b1;
         mem_address_o = addr_a[sel];
         mem_wdata_o   = wdata_a[sel];
         mem_we_o      = data_we_i[sel];
         mem_be_o      = be_a[sel];
      end

      if (push) gnt_o[sel] = 1'b1;
      if (pop)  rvalid_o[fifo_q[rd_ptr_q]] = 1'b1;

      case (lock_q)
         ARB: begin
            if (sel_valid && !mem_gnt_i) begin
               lock_d = HOLD;
               sel_d  = sel;
            end
         end
         HOLD: begin
            if (mem_gnt_i) lock_d = ARB;
         end
         default: lock_d = ARB;
      endcase

      if (push) begin
         rr_d     = (sel == PORT_LAST) ? '0 : sel + IDW'(1);
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
      if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
      if (mem_rvalid_i && cnt_q == '0) err_d = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lock_q   <= ARB;
         sel_q    <= '0;
         rr_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         for (int i = 0; i < int'(MAX_OUTSTANDING); i++) fifo_q[i] <= '0;
      end else begin
         lock_q   <= lock_d;
         sel_q    <= sel_d;
         rr_q     <= rr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         if (push) fifo_q[wr_ptr_q] <= sel;
      end
   end

   assign rdata_o       = mem_rdata_i;
   assign outstanding_o = cnt_q;
   assign err_o         = err_q;

endmodule
